// File: rtl/fir_mac_stage_pkg.sv
// Shared types for the FIR MAC compute stage: control/status structs,
// FSM state encoding and default widths.
package fir_mac_stage_pkg;

    localparam int DEF_DW    = 16;
    localparam int DEF_ACC_W = 40;
    localparam int NTAPS_W   = 8;
    localparam int NOUT_W    = 16;
    localparam int SHIFT_W   = 5;

    typedef struct packed {
        logic               start;
        logic [NTAPS_W-1:0] ntaps;
        logic [NOUT_W-1:0]  nout;
        logic [SHIFT_W-1:0] shift;
    } ctrl_mac_t;

    typedef struct packed {
        logic              busy;
        logic              done;
        logic [NOUT_W-1:0] out_cnt;
    } flags_mac_t;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        ROUND,
        OUT,
        DONE
    } fir_mac_state_t;

endpackage

// File: rtl/fir_mac_stage_if.sv
// Sample (x), coefficient (h) and output (y) valid/ready streams of the MAC stage.
interface fir_mac_stage_if
    import fir_mac_stage_pkg::*;
#(
    parameter int DW = DEF_DW
);

    logic                 x_valid_i;
    logic signed [DW-1:0] x_data_i;
    logic                 x_ready_o;
    logic                 h_valid_i;
    logic signed [DW-1:0] h_data_i;
    logic                 h_ready_o;
    logic                 y_valid_o;
    logic signed [DW-1:0] y_data_o;
    logic                 y_ready_i;

    // slave is the MAC stage itself; master is the streamer side feeding it.
    modport slave (
        input  x_valid_i, x_data_i, h_valid_i, h_data_i, y_ready_i,
        output x_ready_o, h_ready_o, y_valid_o, y_data_o
    );

    modport master (
        output x_valid_i, x_data_i, h_valid_i, h_data_i, y_ready_i,
        input  x_ready_o, h_ready_o, y_valid_o, y_data_o
    );

endinterface

// File: rtl/fir_round_sat.sv
// Round-half-up, arithmetic right shift and saturate an accumulator to DW bits.
// Purely combinational so later stages can reuse it.
module fir_round_sat
    import fir_mac_stage_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic signed [ACC_W-1:0]   acc,
    input  logic        [SHIFT_W-1:0] shift,
    output logic signed [DW-1:0]      sat
);

    localparam logic signed [ACC_W:0] MAX_V = {{(ACC_W+2-DW){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W:0] MIN_V = {{(ACC_W+2-DW){1'b1}}, {(DW-1){1'b0}}};

    logic signed [ACC_W:0] bias;
    logic signed [ACC_W:0] sum;
    logic signed [ACC_W:0] shifted;

    // One extra bit so the rounding bias can never wrap a large positive sum.
    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        bias = '0;
        if (shift != '0) begin
            bias = (ACC_W+1)'(1) << (shift - SHIFT_W'(1));
        end
        sum     = {acc[ACC_W-1], acc} + bias;
        shifted = sum >>> shift;
        if (shifted > MAX_V) begin
            sat = MAX_V[DW-1:0];
        end else if (shifted < MIN_V) begin
            sat = MIN_V[DW-1:0];
        end else begin
            sat = shifted[DW-1:0];
        end
    end

endmodule

// File: rtl/fir_mac_stage.sv
// FIR MAC stage: joins x/h beats, accumulates NTAPS products per output and
// emits one rounded, shifted, saturated sample per accumulation on the y stream.
module fir_mac_stage
    import fir_mac_stage_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int ACC_W = DEF_ACC_W   // must be >= 2*DW
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clear_i,
    input  ctrl_mac_t       ctrl_i,
    output flags_mac_t      flags_o,
    fir_mac_stage_if.slave  strm
);

    fir_mac_state_t          state;
    logic signed [ACC_W-1:0] acc;
    logic [NTAPS_W-1:0]      tap_cnt;
    logic [NOUT_W-1:0]       out_cnt;
    logic [NTAPS_W-1:0]      ntaps_q;
    logic [NOUT_W-1:0]       nout_q;
    logic [SHIFT_W-1:0]      shift_q;
    logic                    y_valid_q;
    logic signed [DW-1:0]    y_data_q;
    logic                    done_q;

    logic                    accum_st;
    logic                    fire;
    logic signed [2*DW-1:0]  prod;
    logic signed [DW-1:0]    rounded;

    // Join: each side is ready only when the other side has data, so a tap
    // is taken from both streams in the same cycle or from neither.
    assign accum_st       = (state == ACCUM);
    assign strm.x_ready_o = accum_st && strm.h_valid_i;
    assign strm.h_ready_o = accum_st && strm.x_valid_i;
    assign fire           = accum_st && strm.x_valid_i && strm.h_valid_i;

    assign prod = (2*DW)'(strm.x_data_i) * (2*DW)'(strm.h_data_i);

    fir_round_sat #(
        .DW    (DW),
        .ACC_W (ACC_W)
    ) u_round_sat (
        .acc   (acc),
        .shift (shift_q),
        .sat   (rounded)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state     <= IDLE;
            acc       <= '0;
            tap_cnt   <= '0;
            out_cnt   <= '0;
            ntaps_q   <= '0;
            nout_q    <= '0;
            shift_q   <= '0;
            y_valid_q <= 1'b0;
            y_data_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (ctrl_i.start) begin
                        ntaps_q <= ctrl_i.ntaps;
                        nout_q  <= ctrl_i.nout;
                        shift_q <= ctrl_i.shift;
                        acc     <= '0;
                        tap_cnt <= '0;
                        out_cnt <= '0;
                        state   <= (ctrl_i.ntaps == '0 || ctrl_i.nout == '0) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (fire) begin
                        acc     <= acc + ACC_W'(prod);
                        tap_cnt <= tap_cnt + NTAPS_W'(1);
                        if (tap_cnt == ntaps_q - NTAPS_W'(1)) begin
                            state <= ROUND;
                        end
                    end
                end
                ROUND: begin
                    y_data_q  <= rounded;
                    y_valid_q <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (strm.y_ready_i) begin
                        y_valid_q <= 1'b0;
                        out_cnt   <= out_cnt + NOUT_W'(1);
                        acc       <= '0;
                        tap_cnt   <= '0;
                        state     <= (out_cnt + NOUT_W'(1) == nout_q) ? DONE : ACCUM;
                    end
                end
                DONE: begin
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign strm.y_valid_o = y_valid_q;
    assign strm.y_data_o  = y_data_q;

    assign flags_o = '{busy: (state != IDLE), done: done_q, out_cnt: out_cnt};

endmodule
